// File: rtl/data_mem_pkg.sv
// Shared types and default sizing for the data memory controller.
package data_mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 256;
    localparam int ADDR_W_DEF = 8;

endpackage

// File: rtl/data_mem_if.sv
// Request/response bus between a requester (master) and the memory controller (slave).
interface data_mem_if
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    localparam int BE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read.
module data_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   be_i,
    output wire  [DATA_W-1:0]     rdata_o
);
    localparam int BE_W = DATA_W / 8;

    // One byte-wide RAM per lane; the read register only updates on a read so it
    // holds its value while a response is stalled downstream.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (en_i) begin
                if (we_i) begin
                    if (be_i[gi]) begin
                        mem_q[addr_i] <= wdata_i[gi*8 +: 8];
                    end
                end else begin
                    rd_q <= mem_q[addr_i];
                end
            end
        end

        assign rdata_o[gi*8 +: 8] = rd_q;
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory controller: fills the array with word[i] = i after reset, then serves
// read/write requests with a one-cycle, back-pressurable response.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    data_mem_if.slave bus,
    output logic      init_done
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("data_mem_ctrl: DATA_W must be a multiple of 8");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("data_mem_ctrl: DEPTH must be at least 2");
    end
    if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
        $error("data_mem_ctrl: ADDR_W too small for DEPTH");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_rd_q, rsp_rd_d;

    logic              req_ready;
    logic              accept;
    logic              addr_ok;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    wire  [DATA_W-1:0] mem_rdata;
    wire  [DATA_W-1:0] init_word;

    // Init pattern is the counter value, zero-extended or truncated to DATA_W.
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_init_word
        if (gi < ADDR_W) begin : g_bit
            assign init_word[gi] = cnt_q[gi];
        end else begin : g_zero
            assign init_word[gi] = 1'b0;
        end
    end

    assign addr_ok   = (32'(bus.req_addr) < DEPTH);
    assign req_ready = (state_q == ST_RUN) && (!rsp_valid_q || bus.rsp_ready);
    assign accept    = bus.req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rd_q    <= rsp_rd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rd_d    = rsp_rd_q;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = bus.req_addr;
        mem_wdata   = bus.req_wdata;
        mem_be      = bus.req_be;

        case (state_q)
            ST_INIT: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = init_word;
                mem_be    = '1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                if (accept) begin
                    // Out-of-range requests never touch the array.
                    mem_en      = addr_ok;
                    mem_we      = bus.req_we;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !addr_ok;
                    rsp_rd_d    = !bus.req_we && addr_ok;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rd_d    = 1'b0;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .be_i    (mem_be),
        .rdata_o (mem_rdata)
    );

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rd_q ? mem_rdata : '0;
    assign init_done     = (state_q == ST_RUN);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: directed cases plus randomized traffic vs. an array model.
module tb_data_mem_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 200;
    localparam int AW    = 8;
    localparam int BEW   = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic init_done;

    always #5 clk = ~clk;

    data_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    data_mem_ctrl #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW:0]   exp_q [$];       // {err, rdata}
    bit            rand_mode = 1'b0;
    bit            ready_on_issue = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_init();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i);
    endfunction

    // Behavioural effect of one accepted request; returns the expected response.
    function automatic logic [DW:0] model_access(input logic we, input logic [AW-1:0] addr,
                                                 input logic [DW-1:0] wdata, input logic [BEW-1:0] be);
        logic [DW-1:0] word;
        if (int'(addr) >= DEPTH) return {1'b1, {DW{1'b0}}};
        if (we) begin
            word = ref_mem[addr];
            for (int b = 0; b < BEW; b++) if (be[b]) word[b*8 +: 8] = wdata[b*8 +: 8];
            ref_mem[addr] = word;
            return {1'b0, {DW{1'b0}}};
        end
        return {1'b0, ref_mem[addr]};
    endfunction

    // Monitor: pops on every response handshake and checks hold-stability while stalled.
    initial begin : monitor
        logic        prev_stall;
        logic [DW:0] prev;
        logic [DW:0] e;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid && prev_stall)
                check("rsp_hold", {bus.rsp_err, bus.rsp_rdata}, prev);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got err=%0b rdata=0x%0h, expected no response (t=%0t)",
                             bus.rsp_err, bus.rsp_rdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp", {bus.rsp_err, bus.rsp_rdata}, e);
                    $display("rsp err=%0b rdata=0x%08h (t=%0t)", bus.rsp_err, bus.rsp_rdata, $time);
                end
            end
            prev_stall = bus.rsp_valid && !bus.rsp_ready;
            prev = {bus.rsp_err, bus.rsp_rdata};
        end
    end

    initial begin : ready_gen
        forever begin
            @(negedge clk);
            if (rand_mode) bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [BEW-1:0] be, output int waited);
        waited = 0;
        @(negedge clk);
        if (ready_on_issue) bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        #1;
        while (!bus.req_ready && waited < 64) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: got req_ready=0 for %0d cycles, expected acceptance (addr=0x%0h)",
                     waited, addr);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(model_access(we, addr, wdata, be));
        $display("req we=%0b addr=0x%02h wdata=0x%08h be=%04b waited=%0d", we, addr, wdata, be, waited);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (n < 1000) begin
            @(posedge clk);
            n++;
            #1;
            if (init_done) break;
        end
        check(name, 64'(n), 64'd200);
        model_init();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_rdata"}, 64'(bus.rsp_rdata), 64'd0);
        check({tag, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
        check({tag, "_init_done"}, 64'(init_done),     64'd0);
        check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int w;
        int w2;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b1;

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait_init("init_latency");

        do_req(1'b0, 8'h05, '0, '0, w);
        do_req(1'b1, 8'h10, 32'hAABBCCDD, 4'b0101, w);
        do_req(1'b0, 8'h10, '0, '0, w);
        do_req(1'b0, 8'hC8, '0, '0, w);
        do_req(1'b0, 8'hC7, '0, '0, w);
        idle();
        idle();

        // Stall the response of a read for three cycles, then release and issue together.
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 8'h20, '0, '0, w);
        repeat (3) begin
            idle();
            #1;
            check("stall_req_ready", 64'(bus.req_ready), 64'd0);
            check("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("stall_rdata",     64'(bus.rsp_rdata), 64'h20);
        end
        ready_on_issue = 1'b1;
        do_req(1'b0, 8'h21, '0, '0, w);
        ready_on_issue = 1'b0;
        check("release_same_cycle_accept", 64'(w), 64'd0);

        do_req(1'b1, 8'h30, 32'h12345678, 4'hF, w);
        do_req(1'b0, 8'h30, '0, '0, w2);
        check("b2b_write_wait", 64'(w), 64'd0);
        check("b2b_read_wait",  64'(w2), 64'd0);
        idle();
        idle();

        // Randomized traffic with random back-pressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            else do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 215)), DW'($urandom),
                        BEW'($urandom_range(0, 15)), w);
        end
        rand_mode = 1'b0;
        idle();
        bus.rsp_ready = 1'b1;
        repeat (4) idle();
        check("queue_drained_random", 64'(exp_q.size()), 64'd0);

        // Reset while a response is pending.
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 8'h40, '0, '0, w);
        idle();
        rst_n = 1'b0;
        #1 check_reset_outputs("run_rst");
        exp_q.delete();
        bus.rsp_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        wait_init("init_latency_after_run_rst");

        // Reset in the middle of initialisation.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1 check_reset_outputs("init_rst");
        @(negedge clk) rst_n = 1'b1;
        wait_init("init_latency_after_init_rst");

        do_req(1'b0, 8'h00, '0, '0, w);
        do_req(1'b0, 8'h10, '0, '0, w);
        do_req(1'b0, 8'h30, '0, '0, w);
        do_req(1'b0, 8'h31, '0, '0, w);
        do_req(1'b0, 8'hC7, '0, '0, w);
        repeat (4) idle();
        check("queue_drained_final", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
